// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: decoupling FIFO between IFU fetch (ICache + BPU) and decode.
// Each entry holds one fetch bundle: PC, INSTR_PER_FETCH instructions,
// per-slot valid mask and the branch prediction.
//
// Handshake rules:
//   - A push happens when in_valid_i && in_ready_o && !flush_i.
//   - A pop happens when out_valid_o && out_ready_i.
//   - in_ready_o depends only on the registered count, never on out_ready_i.
//
// Optional feature: define IFU_FETCHQ_BYPASS_EN to let a bundle pass through
// an empty queue in the same cycle when decode is ready. Without it, every
// bundle takes one cycle from input to output and no in_* input reaches an
// out_* output combinationally.
module ifu_fetch_queue #(
    parameter int INSTR_PER_FETCH = 4,
    parameter int ILEN            = 32,
    parameter int XLEN            = 32,
    parameter int DEPTH           = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [XLEN-1:0]                 in_pc_i,
    input  logic [INSTR_PER_FETCH*ILEN-1:0] in_instrs_i,
    input  logic [INSTR_PER_FETCH-1:0]      in_slot_valid_i,
    input  logic                            in_pred_taken_i,
    input  logic [XLEN-1:0]                 in_pred_target_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [XLEN-1:0]                 out_pc_o,
    output logic [INSTR_PER_FETCH*ILEN-1:0] out_instrs_o,
    output logic [INSTR_PER_FETCH-1:0]      out_slot_valid_o,
    output logic                            out_pred_taken_o,
    output logic [XLEN-1:0]                 out_pred_target_o,
    output logic [$clog2(DEPTH):0]          count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    // Bundle storage; contents need no reset because count gates visibility.
    logic [XLEN-1:0]                 pc_mem     [DEPTH];
    logic [INSTR_PER_FETCH*ILEN-1:0] instr_mem  [DEPTH];
    logic [INSTR_PER_FETCH-1:0]      mask_mem   [DEPTH];
    logic                            taken_mem  [DEPTH];
    logic [XLEN-1:0]                 target_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic queue_empty;
    logic mask_nonzero;
    logic push_hs;
    logic bypass_fire;
    logic push_store;
    logic pop_store;

    assign queue_empty  = (count == '0);
    assign mask_nonzero = |in_slot_valid_i;
    assign in_ready_o   = (count != FULL_COUNT);
    assign count_o      = count;

    // Handshaken push; an empty-mask bundle is accepted but never stored.
    assign push_hs = in_valid_i && in_ready_o && !flush_i;

`ifdef IFU_FETCHQ_BYPASS_EN
    // Empty queue with decode ready: the bundle goes straight to the outputs.
    assign bypass_fire = queue_empty && in_valid_i && mask_nonzero &&
                         out_ready_i && !flush_i;
    assign out_valid_o = (!queue_empty || bypass_fire) && !flush_i;
`else
    assign bypass_fire = 1'b0;
    assign out_valid_o = !queue_empty && !flush_i;
`endif

    assign push_store = push_hs && mask_nonzero && !bypass_fire;
    // A bypassed bundle is consumed without touching storage.
    assign pop_store  = out_valid_o && out_ready_i && !queue_empty;

    // Output payload: head entry, the bypassed input, or zero when idle.
    always_comb begin
        out_pc_o          = '0;
        out_instrs_o      = '0;
        out_slot_valid_o  = '0;
        out_pred_taken_o  = 1'b0;
        out_pred_target_o = '0;
        if (out_valid_o) begin
            if (!queue_empty) begin
                out_pc_o          = pc_mem[rd_ptr];
                out_instrs_o      = instr_mem[rd_ptr];
                out_slot_valid_o  = mask_mem[rd_ptr];
                out_pred_taken_o  = taken_mem[rd_ptr];
                out_pred_target_o = target_mem[rd_ptr];
            end else if (bypass_fire) begin
                out_pc_o          = in_pc_i;
                out_instrs_o      = in_instrs_i;
                out_slot_valid_o  = in_slot_valid_i;
                out_pred_taken_o  = in_pred_taken_i;
                out_pred_target_o = in_pred_target_i;
            end
        end
    end

    // Write the incoming bundle into the slot at the write pointer.
    always_ff @(posedge clk_i) begin
        if (push_store) begin
            pc_mem[wr_ptr]     <= in_pc_i;
            instr_mem[wr_ptr]  <= in_instrs_i;
            mask_mem[wr_ptr]   <= in_slot_valid_i;
            taken_mem[wr_ptr]  <= in_pred_taken_i;
            target_mem[wr_ptr] <= in_pred_target_i;
        end
    end

    // Pointer and occupancy update; flush overrides push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_store) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_store, pop_store})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
